// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache package: arbiter state encodings, widths and the ownership hold limit.
package cache_mem_arbiter_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned HOLD_W     = 7;
    localparam int unsigned HOLD_LIMIT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        I_OWN = 2'b01,
        D_OWN = 2'b10
    } arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter_hold_counter.sv
// Saturating ownership-length counter: synchronous clear, count enable, sticks at all-ones.
module hold_counter
    import cache_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [HOLD_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cnt <= '0;
        else if (clr)                 cnt <= '0;
        else if (en && (cnt != '1))   cnt <= cnt + HOLD_W'(1);
    end

endmodule

// File: rtl/dff.sv
// Generic D flip-flop cell with asynchronous active-high reset to a parameterised value.
module dff #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter giving the I-cache or D-cache exclusive ownership of the memory port.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_req,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_wr,
    input  logic [DATA_W-1:0] dcache_wdata,
    output logic              icache_grant,
    output logic              dcache_grant,
    output logic              icache_stall,
    output logic              dcache_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              arb_timeout
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [1:0]        state_raw;
    logic              last_q;
    logic              last_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic              owner;
    logic              timeout_q;

    dff #(.W(2), .RST_VAL(2'(IDLE))) u_state_ff (
        .clk (clk),
        .rst (rst),
        .d   (2'(state_d)),
        .q   (state_raw)
    );

    // last_owner resets to D so the I-cache wins the first tie
    dff #(.W(1), .RST_VAL(1'b1)) u_last_ff (
        .clk (clk),
        .rst (rst),
        .d   (last_d),
        .q   (last_q)
    );

    assign state_q = arb_state_e'(state_raw);
    assign owner   = (state_q != IDLE);

    // Next state: owners always pass back through IDLE, so the grant bubble is guaranteed
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (icache_req && (!dcache_req || last_q)) begin
                    state_d = I_OWN;
                    last_d  = 1'b0;
                end else if (dcache_req) begin
                    state_d = D_OWN;
                    last_d  = 1'b1;
                end
            end
            I_OWN:   if (!icache_req) state_d = IDLE;
            D_OWN:   if (!dcache_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    hold_counter u_hold (
        .clk (clk),
        .rst (rst),
        .clr (!owner),
        .en  (owner),
        .cnt (hold_cnt)
    );

    // Sticky: set on the edge where the hold count reaches the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_q <= 1'b0;
        else if (owner && (hold_cnt == HOLD_W'(HOLD_LIMIT - 1)))
            timeout_q <= 1'b1;
    end

    assign arb_timeout  = timeout_q;
    assign icache_grant = (state_q == I_OWN);
    assign dcache_grant = (state_q == D_OWN);
    // Stalls are masked by rst so every output is quiet during reset
    assign icache_stall = icache_req & ~icache_grant & ~rst;
    assign dcache_stall = dcache_req & ~dcache_grant & ~rst;
    assign mem_enable   = icache_grant | dcache_grant;
    assign mem_addr     = icache_grant ? icache_addr :
                          dcache_grant ? dcache_addr : '0;
    assign mem_wr       = dcache_grant & dcache_wr;
    assign mem_wdata    = mem_wr ? dcache_wdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: grants, round-robin, bubble, writes, timeout, async reset.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_req;
    logic [15:0] icache_addr;
    logic        dcache_req;
    logic [15:0] dcache_addr;
    logic        dcache_wr;
    logic [15:0] dcache_wdata;
    logic        icache_grant;
    logic        dcache_grant;
    logic        icache_stall;
    logic        dcache_stall;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic        arb_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .dcache_req   (dcache_req),
        .dcache_addr  (dcache_addr),
        .dcache_wr    (dcache_wr),
        .dcache_wdata (dcache_wdata),
        .icache_grant (icache_grant),
        .dcache_grant (dcache_grant),
        .icache_stall (icache_stall),
        .dcache_stall (dcache_stall),
        .mem_addr     (mem_addr),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .arb_timeout  (arb_timeout)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every output must be zero (used during reset and in IDLE with no requests)
    task automatic chk_quiet(input string tag);
        chk({tag, ".igrant"}, 16'(icache_grant), 16'h0);
        chk({tag, ".dgrant"}, 16'(dcache_grant), 16'h0);
        chk({tag, ".istall"}, 16'(icache_stall), 16'h0);
        chk({tag, ".dstall"}, 16'(dcache_stall), 16'h0);
        chk({tag, ".addr"},   mem_addr,          16'h0000);
        chk({tag, ".en"},     16'(mem_enable),   16'h0);
        chk({tag, ".wr"},     16'(mem_wr),       16'h0);
        chk({tag, ".wdata"},  mem_wdata,         16'h0000);
    endtask

    initial begin
        rst = 1'b1;
        icache_req = 1'b0; icache_addr = 16'h1230;
        dcache_req = 1'b0; dcache_addr = 16'h4560;
        dcache_wr  = 1'b0; dcache_wdata = 16'h0000;

        // Reset: everything low, even with requests asserted
        #12;
        icache_req = 1'b1; dcache_req = 1'b1;
        #1;
        chk_quiet("reset");
        chk("reset.timeout", 16'(arb_timeout), 16'h0);
        icache_req = 1'b0; dcache_req = 1'b0;

        // Lone I-cache request: grant after one edge
        @(negedge clk);
        rst = 1'b0;
        icache_req = 1'b1;
        #1;
        chk("i_alone.pre_grant", 16'(icache_grant), 16'h0);
        chk("i_alone.pre_stall", 16'(icache_stall), 16'h1);
        cyc();
        chk("i_alone.grant", 16'(icache_grant), 16'h1);
        chk("i_alone.addr",  mem_addr,          16'h1230);
        chk("i_alone.en",    16'(mem_enable),   16'h1);
        chk("i_alone.dstall",16'(dcache_stall), 16'h0);
        chk("i_alone.istall",16'(icache_stall), 16'h0);
        chk("i_alone.wr",    16'(mem_wr),       16'h0);

        // Drop: back to IDLE
        @(negedge clk);
        icache_req = 1'b0;
        cyc();
        chk_quiet("i_drop");

        // Tie after I owned last: round-robin favours D
        @(negedge clk);
        icache_req = 1'b1; dcache_req = 1'b1;
        cyc();
        chk("rr.dgrant", 16'(dcache_grant), 16'h1);
        chk("rr.igrant", 16'(icache_grant), 16'h0);
        chk("rr.istall", 16'(icache_stall), 16'h1);
        chk("rr.addr",   mem_addr,          16'h4560);
        @(negedge clk);
        icache_req = 1'b0; dcache_req = 1'b0;
        cyc();

        // Fresh reset, tie: I wins first; hold 20 cycles
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        icache_req = 1'b1; dcache_req = 1'b1;
        cyc();
        chk("tie.igrant", 16'(icache_grant), 16'h1);
        chk("tie.dgrant", 16'(dcache_grant), 16'h0);
        for (int k = 2; k <= 20; k++) begin
            cyc();
            chk("tie.hold_igrant", 16'(icache_grant), 16'h1);
            chk("tie.hold_dstall", 16'(dcache_stall), 16'h1);
        end
        @(negedge clk);
        icache_req = 1'b0;
        cyc();
        chk("bubble.igrant", 16'(icache_grant), 16'h0);
        chk("bubble.dgrant", 16'(dcache_grant), 16'h0);
        chk("bubble.en",     16'(mem_enable),   16'h0);
        chk("bubble.dstall", 16'(dcache_stall), 16'h1);
        cyc();
        chk("d_own.dgrant",  16'(dcache_grant), 16'h1);
        chk("d_own.addr",    mem_addr,          16'h4560);

        // D write while I requests: combinational mem_wr, I stalled
        icache_req = 1'b1; dcache_wr = 1'b1; dcache_wdata = 16'hBEEF;
        #1;
        chk("d_wr.wr",     16'(mem_wr),       16'h1);
        chk("d_wr.wdata",  mem_wdata,         16'hBEEF);
        chk("d_wr.istall", 16'(icache_stall), 16'h1);
        cyc();
        chk("d_wr.hold",   16'(dcache_grant), 16'h1);
        chk("d_wr.istall2",16'(icache_stall), 16'h1);
        dcache_wr = 1'b0;
        #1;
        chk("d_rd.wr",     16'(mem_wr),       16'h0);
        chk("d_rd.wdata",  mem_wdata,         16'h0000);
        chk("d_rd.dgrant", 16'(dcache_grant), 16'h1);
        dcache_wr = 1'b1;

        // Asynchronous reset mid-ownership
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("async_rst");
        @(negedge clk);
        rst = 1'b0;
        dcache_wr = 1'b0;
        cyc();
        chk("post_rst.igrant", 16'(icache_grant), 16'h1);
        chk("post_rst.dgrant", 16'(dcache_grant), 16'h0);
        chk("post_rst.timeout",16'(arb_timeout),  16'h0);

        // Hold I for 70 cycles: timeout visible once 64 edges have elapsed in ownership
        for (int k = 1; k <= 69; k++) begin
            cyc();
            chk($sformatf("timeout.k%0d", k), 16'(arb_timeout), (k >= 64) ? 16'h1 : 16'h0);
        end
        chk("timeout.still_igrant", 16'(icache_grant), 16'h1);
        @(negedge clk);
        icache_req = 1'b0;
        cyc();
        chk("timeout.sticky_idle", 16'(arb_timeout),  16'h1);
        chk("timeout.bubble",      16'(dcache_grant), 16'h0);
        cyc();
        chk("timeout.d_grant",     16'(dcache_grant), 16'h1);
        chk("timeout.sticky_d",    16'(arb_timeout),  16'h1);

        // Only reset clears the flag
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("timeout.cleared", 16'(arb_timeout), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
